// File: rtl/chunk_accumulator54_pkg.sv
// Shared definitions for the chunked 54-bit accumulator and its 54+15-bit adder.
package chunk_accumulator54_pkg;

    localparam int ACC_W = 54;
    localparam int ADD_W = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } acc_state_t;

endpackage

// File: rtl/chunk_accumulator54_adder.sv
// Combinational 54+15-bit chunk adder; bit ACC_W of the sum is the carry-out.
module customAdder54_39
    import chunk_accumulator54_pkg::*;
(
    input  logic [ACC_W-1:0] a_i,
    input  logic [ADD_W-1:0] b_i,
    output logic [ACC_W:0]   sum_o
);

    assign sum_o = {1'b0, a_i} + {{(ACC_W+1-ADD_W){1'b0}}, b_i};

endmodule

// File: rtl/chunk_accumulator54.sv
// Streams 15-bit addends into a 54-bit running sum, then presents the wrapped
// sum, a sticky carry-out flag and a saturating beat count over valid/ready.
module chunk_accumulator54
    import chunk_accumulator54_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ACC_W-1:0] init_val,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ADD_W-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_count
);

    acc_state_t       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [ACC_W:0]   sum;

    customAdder54_39 u_adder (
        .a_i   (acc_q),
        .b_i   (in_data),
        .sum_o (sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = init_val;
                    ovf_d   = 1'b0;
                    count_d = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    acc_d = sum[ACC_W-1:0];
                    ovf_d = ovf_q | sum[ACC_W];
                    // beat count sticks at all-ones rather than wrapping
                    if (count_q != {CNT_W{1'b1}}) begin
                        count_d = count_q + CNT_W'(1);
                    end
                    if (in_last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign out_sum   = acc_q;
    assign out_ovf   = ovf_q;
    assign out_count = count_q;

endmodule

// File: tb/tb_chunk_accumulator54.sv
// Directed bench for chunk_accumulator54 with an expected-result queue.
module tb_chunk_accumulator54;

    logic        clk;
    logic        rst;
    logic        start;
    logic [53:0] init_val;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [53:0] out_sum;
    logic        out_ovf;
    logic [7:0]  out_count;

    typedef struct packed {
        logic [53:0] sum;
        logic        ovf;
        logic [7:0]  cnt;
    } exp_t;

    exp_t        exp_q[$];
    logic [53:0] m_acc;
    logic        m_ovf;
    logic [7:0]  m_cnt;
    int          checks;
    int          errors;

    chunk_accumulator54 #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .init_val  (init_val),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic do_start(input logic [53:0] v);
        @(negedge clk);
        start    = 1'b1;
        init_val = v;
        m_acc    = v;
        m_ovf    = 1'b0;
        m_cnt    = 8'd0;
        @(negedge clk);
        start = 1'b0;
        chk("in_ready_after_start", {63'd0, in_ready}, 64'd1);
    endtask

    // Drives one beat at a negedge; it is accepted on the following posedge.
    task automatic send_beat(input logic [14:0] d, input logic last);
        logic [54:0] s;
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $error("FAIL beat_ready: observed=%0b expected=1", in_ready);
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        s     = {1'b0, m_acc} + {40'd0, d};
        m_acc = s[53:0];
        m_ovf = m_ovf | s[54];
        if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        if (last) exp_q.push_back('{sum: m_acc, ovf: m_ovf, cnt: m_cnt});
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        $display("beat data=%04h last=%0b", d, last);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
    endtask

    task automatic check_result(input string tag);
        int   n;
        exp_t e;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'd0);
        chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_queue: observed=empty expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_sum"}, {10'd0, out_sum}, {10'd0, e.sum});
            chk({tag, "_ovf"}, {63'd0, out_ovf}, {63'd0, e.ovf});
            chk({tag, "_count"}, {56'd0, out_count}, {56'd0, e.cnt});
            $display("result %s sum=%0h ovf=%0b count=%0d", tag, out_sum, out_ovf, out_count);
        end
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_idle_valid"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_idle_ready"}, {63'd0, in_ready}, 64'd0);
    endtask

    initial begin
        logic [53:0] held_sum;
        logic [7:0]  held_cnt;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        init_val  = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_sum", {10'd0, out_sum}, 64'd0);
        chk("rst_out_ovf", {63'd0, out_ovf}, 64'd0);
        chk("rst_out_count", {56'd0, out_count}, 64'd0);
        rst = 1'b0;
        idle_cycle();
        chk("idle_no_start", {63'd0, in_ready}, 64'd0);

        // Three max chunks from zero
        do_start(54'd0);
        send_beat(15'h7FFF, 1'b0);
        send_beat(15'h7FFF, 1'b0);
        send_beat(15'h7FFF, 1'b1);
        chk("t1_sum_const", {10'd0, out_sum}, 64'h17FFD);
        check_result("t1");
        handshake("t1");

        // Wrap from all-ones
        do_start({54{1'b1}});
        send_beat(15'h0001, 1'b1);
        chk("t2_ovf_const", {63'd0, out_ovf}, 64'd1);
        check_result("t2");
        handshake("t2");

        // Valid gaps: registers hold while in_valid is low
        do_start(54'd10);
        send_beat(15'd5, 1'b0);
        idle_cycle();
        idle_cycle();
        chk("t3_gap_sum", {10'd0, out_sum}, 64'd15);
        chk("t3_gap_count", {56'd0, out_count}, 64'd1);
        send_beat(15'd7, 1'b1);
        chk("t3_sum_const", {10'd0, out_sum}, 64'd22);
        check_result("t3");

        // Back-pressure in DONE, including a stray start
        held_sum = out_sum;
        held_cnt = out_count;
        for (int i = 0; i < 5; i++) begin
            start    = (i == 2);
            init_val = 54'd999;
            @(negedge clk);
            chk("t4_hold_valid", {63'd0, out_valid}, 64'd1);
            chk("t4_hold_sum", {10'd0, out_sum}, {10'd0, held_sum});
            chk("t4_hold_count", {56'd0, out_count}, {56'd0, held_cnt});
            chk("t4_hold_ready", {63'd0, in_ready}, 64'd0);
        end
        start = 1'b1;
        handshake("t4");
        start = 1'b0;
        chk("t4_start_ignored_sum", {10'd0, out_sum}, {10'd0, held_sum});

        // Start pulsed mid-accumulation is ignored
        do_start(54'd100);
        send_beat(15'd1, 1'b0);
        send_beat(15'd1, 1'b0);
        start    = 1'b1;
        init_val = 54'd5;
        @(negedge clk);
        start = 1'b0;
        chk("t5_start_ignored", {10'd0, out_sum}, 64'd102);
        send_beat(15'd1, 1'b1);
        chk("t5_sum_const", {10'd0, out_sum}, 64'd103);
        check_result("t5");
        handshake("t5");

        // Beat counter saturation
        do_start(54'd0);
        for (int i = 0; i < 259; i++) send_beat(15'd1, 1'b0);
        send_beat(15'd1, 1'b1);
        chk("t6_count_sat", {56'd0, out_count}, 64'd255);
        check_result("t6");
        handshake("t6");

        // Asynchronous reset mid-accumulation
        do_start(54'd1234);
        send_beat(15'd3, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("t7_rst_ready", {63'd0, in_ready}, 64'd0);
        chk("t7_rst_sum", {10'd0, out_sum}, 64'd0);
        chk("t7_rst_count", {56'd0, out_count}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1;
        in_data  = 15'd9;
        in_last  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("t7_idle_ready", {63'd0, in_ready}, 64'd0);
        chk("t7_idle_valid", {63'd0, out_valid}, 64'd0);
        chk("t7_idle_sum", {10'd0, out_sum}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
